// File: rtl/param_insert_sort.sv
// ---------------------------------------------------------------------------
// param_insert_sort
//   Parametrised insertion-sort engine. Records (color, total, index) are
//   inserted one per cycle into a sorted slot array. A batch drains in sorted
//   order over a ready/valid port when the array fills, or earlier on flush.
//
//   Optional feature macro: COLOR_GROUP_EN
//     defined   -> sort key is {color, total}, so the drain is grouped by color
//     undefined -> sort key is total only, and color is carried as payload
//
// Ports
//   clk              rising-edge clock
//   rst              synchronous active-low reset
//   in_valid         input record valid (ignored while busy)
//   color/total/index  input record fields
//   flush            drain a partial batch (ignored when empty and no insert)
//   out_ready        downstream accepts the record shown on the outputs
//   busy             high while draining
//   out_valid        output record valid
//   color_index, image_out_index, total_out  record in slot 0
//   count            records currently held
// ---------------------------------------------------------------------------
module param_insert_sort #(
  parameter int DEPTH   = 32,
  parameter int KW      = 23,
  parameter int IW      = 5,
  parameter int CW      = 2,
  parameter int DESCEND = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [CW-1:0]                color,
  input  logic [KW-1:0]                total,
  input  logic [IW-1:0]                index,
  input  logic                         flush,
  input  logic                         out_ready,
  output logic                         busy,
  output logic                         out_valid,
  output logic [CW-1:0]                color_index,
  output logic [IW-1:0]                image_out_index,
  output logic [KW-1:0]                total_out,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CNTW = $clog2(DEPTH+1);
`ifdef COLOR_GROUP_EN
  localparam int SKW = CW + KW;
`else
  localparam int SKW = KW;
`endif

  typedef struct packed {
    logic [CW-1:0] color;
    logic [KW-1:0] total;
    logic [IW-1:0] index;
  } rec_t;

  typedef enum logic {LOAD, DRAIN} state_t;

  state_t           state;
  rec_t             slots     [DEPTH];
  rec_t             ins_slots [DEPTH];
  rec_t             pop_slots [DEPTH];
  logic [DEPTH-1:0] after;
  rec_t             new_rec;
  logic             ins;
  logic             fills;
  logic             go_drain;

  function automatic logic [SKW-1:0] key_of(input rec_t r);
`ifdef COLOR_GROUP_EN
    return {r.color, r.total};
`else
    return r.total;
`endif
  endfunction

  assign new_rec = '{color: color, total: total, index: index};

  // Outputs come straight from the slot-0 register, so there is no
  // combinational path from any input to the output fields.
  assign color_index     = slots[0].color;
  assign image_out_index = slots[0].index;
  assign total_out       = slots[0].total;

  assign ins      = (state == LOAD) && in_valid && (count < CNTW'(DEPTH));
  assign fills    = ins && (count == CNTW'(DEPTH - 1));
  assign go_drain = fills || (flush && (ins || (count != '0)));

  // NOTE: combinational logic uses blocking '=' and assigns every output a
  // default first, so no latch can be inferred on any path.
  always_comb begin
    // A slot is "after" the new record when it is occupied and strictly
    // ordered behind it; equal keys stay ahead, which keeps ties stable.
    for (int i = 0; i < DEPTH; i++) begin
      after[i] = 1'b0;
      if (CNTW'(i) < count) begin
        if (DESCEND != 0) after[i] = key_of(slots[i]) < key_of(new_rec);
        else              after[i] = key_of(slots[i]) > key_of(new_rec);
      end
    end

    // Insert view: slots after the new key move down one; the new record
    // lands at the first "after" slot, or at the tail if none.
    ins_slots[0] = (after[0] || (count == '0)) ? new_rec : slots[0];
    for (int i = 1; i < DEPTH; i++) begin
      ins_slots[i] = slots[i];
      if (after[i-1])                          ins_slots[i] = slots[i-1];
      else if (after[i] || (CNTW'(i) == count)) ins_slots[i] = new_rec;
    end

    // Pop view: everything moves up one, tail is zero-filled.
    for (int i = 0; i < DEPTH - 1; i++) pop_slots[i] = slots[i+1];
    pop_slots[DEPTH-1] = '0;
  end

  // NOTE: sequential state uses non-blocking '<=' only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= LOAD;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      count     <= '0;
      // NOTE: the slot array is reset explicitly because slot 0 drives the
      // outputs and vacated slots must read as zero after reset.
      for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (ins) begin
            slots <= ins_slots;
            count <= count + CNTW'(1);
          end
          if (go_drain) begin
            state     <= DRAIN;
            busy      <= 1'b1;
            out_valid <= 1'b1;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            slots <= pop_slots;
            count <= count - CNTW'(1);
            if (count == CNTW'(1)) begin
              state     <= LOAD;
              busy      <= 1'b0;
              out_valid <= 1'b0;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_param_insert_sort.sv
// ---------------------------------------------------------------------------
// tb_param_insert_sort
//   Drives an ascending and a descending DEPTH=4 instance with the same
//   stimulus. Batches come from a table; expected drain records are pushed to
//   per-instance queues when a batch is loaded and popped as the DUTs drain.
//   Hand-written sequences cover empty flush, backpressure and mid-drain reset.
// ---------------------------------------------------------------------------
module tb_param_insert_sort;

  localparam int DEPTH = 4;
  localparam int KW    = 23;
  localparam int IW    = 5;
  localparam int CW    = 2;
  localparam int CNTW  = $clog2(DEPTH+1);

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic [CW-1:0] color;
  logic [KW-1:0] total;
  logic [IW-1:0] index;
  logic flush;
  logic out_ready;

  logic busy_a, out_valid_a, busy_d, out_valid_d;
  logic [CW-1:0] col_a, col_d;
  logic [IW-1:0] idx_a, idx_d;
  logic [KW-1:0] tot_a, tot_d;
  logic [CNTW-1:0] count_a, count_d;

  always #5 clk = ~clk;

  param_insert_sort #(.DEPTH(DEPTH), .KW(KW), .IW(IW), .CW(CW), .DESCEND(0)) u_asc (
    .clk(clk), .rst(rst), .in_valid(in_valid), .color(color), .total(total),
    .index(index), .flush(flush), .out_ready(out_ready), .busy(busy_a),
    .out_valid(out_valid_a), .color_index(col_a), .image_out_index(idx_a),
    .total_out(tot_a), .count(count_a));

  param_insert_sort #(.DEPTH(DEPTH), .KW(KW), .IW(IW), .CW(CW), .DESCEND(1)) u_desc (
    .clk(clk), .rst(rst), .in_valid(in_valid), .color(color), .total(total),
    .index(index), .flush(flush), .out_ready(out_ready), .busy(busy_d),
    .out_valid(out_valid_d), .color_index(col_d), .image_out_index(idx_d),
    .total_out(tot_d), .count(count_d));

  typedef struct packed {
    logic [CW-1:0] col;
    logic [KW-1:0] tot;
    logic [IW-1:0] idx;
  } rec_t;

  // fl: 0 = no flush, 1 = flush with last insert, 2 = flush alone afterwards.
  // ord_a/ord_d list input positions in the expected drain order.
  typedef struct packed {
    logic [2:0]             n;
    logic [1:0]             fl;
    logic [3:0][CW-1:0]     col;
    logic [3:0][KW-1:0]     tot;
    logic [3:0][IW-1:0]     idx;
    logic [3:0][1:0]        ord_a;
    logic [3:0][1:0]        ord_d;
  } batch_t;

  batch_t tbl [4];
  rec_t   q_a [$];
  rec_t   q_d [$];
  int     tests = 0;
  int     fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rec(input int b, input int k, input int c, input int t, input int i);
    tbl[b].col[k] = CW'(c);
    tbl[b].tot[k] = KW'(t);
    tbl[b].idx[k] = IW'(i);
  endtask

  task automatic set_ord(input int b, input int a0, input int a1, input int a2, input int a3,
                         input int d0, input int d1, input int d2, input int d3);
    tbl[b].ord_a[0] = 2'(a0); tbl[b].ord_a[1] = 2'(a1);
    tbl[b].ord_a[2] = 2'(a2); tbl[b].ord_a[3] = 2'(a3);
    tbl[b].ord_d[0] = 2'(d0); tbl[b].ord_d[1] = 2'(d1);
    tbl[b].ord_d[2] = 2'(d2); tbl[b].ord_d[3] = 2'(d3);
  endtask

  task automatic check_out(input string tag, input rec_t ea, input rec_t ed);
    check({tag, " asc idx"},   32'(idx_a), 32'(ea.idx));
    check({tag, " asc total"}, 32'(tot_a), 32'(ea.tot));
    check({tag, " asc color"}, 32'(col_a), 32'(ea.col));
    check({tag, " desc idx"},  32'(idx_d), 32'(ed.idx));
    check({tag, " desc total"},32'(tot_d), 32'(ed.tot));
    check({tag, " desc color"},32'(col_d), 32'(ed.col));
  endtask

  task automatic load_batch(input int b);
    rec_t r;
    for (int k = 0; k < int'(tbl[b].n); k++) begin
      in_valid = 1'b1;
      color    = tbl[b].col[k];
      total    = tbl[b].tot[k];
      index    = tbl[b].idx[k];
      flush    = (tbl[b].fl == 2'd1) && (k == int'(tbl[b].n) - 1);
      tick();
      in_valid = 1'b0;
      flush    = 1'b0;
      check($sformatf("b%0d load count asc", b), 32'(count_a), 32'(k + 1));
      check($sformatf("b%0d load count desc", b), 32'(count_d), 32'(k + 1));
    end
    if (tbl[b].fl == 2'd2) begin
      flush = 1'b1;
      tick();
      flush = 1'b0;
    end
    check($sformatf("b%0d busy asc", b), 32'(busy_a), 1);
    check($sformatf("b%0d busy desc", b), 32'(busy_d), 1);
    for (int k = 0; k < int'(tbl[b].n); k++) begin
      r = '{col: tbl[b].col[tbl[b].ord_a[k]], tot: tbl[b].tot[tbl[b].ord_a[k]],
            idx: tbl[b].idx[tbl[b].ord_a[k]]};
      q_a.push_back(r);
      r = '{col: tbl[b].col[tbl[b].ord_d[k]], tot: tbl[b].tot[tbl[b].ord_d[k]],
            idx: tbl[b].idx[tbl[b].ord_d[k]]};
      q_d.push_back(r);
    end
  endtask

  task automatic drain_check(input string tag);
    int guard = 0;
    out_ready = 1'b1;
    while ((q_a.size() > 0) && (q_d.size() > 0) && (guard < 20)) begin
      guard++;
      check({tag, " out_valid"}, 32'({out_valid_a, out_valid_d}), 32'b11);
      check({tag, " count asc"}, 32'(count_a), 32'(q_a.size()));
      check({tag, " count desc"}, 32'(count_d), 32'(q_d.size()));
      check_out(tag, q_a.pop_front(), q_d.pop_front());
      tick();
    end
    check({tag, " drain left"}, 32'(q_a.size() + q_d.size()), 0);
    check({tag, " end busy"}, 32'({busy_a, busy_d, out_valid_a, out_valid_d}), 0);
    check({tag, " end count"}, 32'({count_a, count_d}), 0);
  endtask

  initial begin
    // Scenario 1: DESCEND=0 -> 3,1,0,2 ; DESCEND=1 -> 2,0,1,3.
    tbl[0] = '0; tbl[0].n = 3'd4; tbl[0].fl = 2'd0;
    set_rec(0, 0, 0, 2514, 0); set_rec(0, 1, 0, 1600, 1);
    set_rec(0, 2, 0, 4512, 2); set_rec(0, 3, 0, 1254, 3);
    set_ord(0, 3, 1, 0, 2, 2, 0, 1, 3);
    // Ties: equal keys keep arrival order in both directions.
    tbl[1] = '0; tbl[1].n = 3'd3; tbl[1].fl = 2'd2;
    set_rec(1, 0, 0, 1000, 5); set_rec(1, 1, 0, 1000, 7); set_rec(1, 2, 0, 1000, 2);
    set_ord(1, 0, 1, 2, 0, 0, 1, 2, 0);
    // Flush together with the third insert.
    tbl[2] = '0; tbl[2].n = 3'd3; tbl[2].fl = 2'd1;
    set_rec(2, 0, 0, 3000, 0); set_rec(2, 1, 0, 10, 1); set_rec(2, 2, 0, 500, 2);
    set_ord(2, 1, 2, 0, 0, 0, 2, 1, 0);
    // Colors {1,0,1,0}, totals {10,40,5,20}.
    tbl[3] = '0; tbl[3].n = 3'd4; tbl[3].fl = 2'd0;
    set_rec(3, 0, 1, 10, 0); set_rec(3, 1, 0, 40, 1);
    set_rec(3, 2, 1, 5, 2);  set_rec(3, 3, 0, 20, 3);
`ifdef COLOR_GROUP_EN
    set_ord(3, 3, 1, 2, 0, 0, 2, 1, 3);
`else
    set_ord(3, 2, 0, 3, 1, 1, 3, 0, 2);
`endif

    rst = 1'b0; in_valid = 1'b0; color = '0; total = '0; index = '0;
    flush = 1'b0; out_ready = 1'b0;
    tick(); tick();
    check("reset flags", 32'({busy_a, out_valid_a, busy_d, out_valid_d}), 0);
    check("reset count", 32'({count_a, count_d}), 0);
    check("reset fields", 32'({col_a, idx_a, tot_a}), 0);
    rst = 1'b1;
    tick();

    // Flush on an empty array is ignored.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("empty flush busy", 32'({busy_a, busy_d}), 0);

    for (int b = 0; b < 3; b++) begin
      load_batch(b);
      drain_check($sformatf("batch%0d", b));
    end

    // Backpressure: pop one, stall 5 cycles with input presented.
    load_batch(0);
    out_ready = 1'b1;
    check_out("bp first", q_a.pop_front(), q_d.pop_front());
    tick();
    out_ready = 1'b0;
    in_valid = 1'b1; color = '0; total = KW'(7); index = IW'(9);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp count", 32'({count_a, count_d}), 32'({3'd3, 3'd3}));
      check("bp flags", 32'({busy_a, out_valid_a, busy_d, out_valid_d}), 32'hF);
      check_out("bp hold", q_a[0], q_d[0]);
    end
    in_valid = 1'b0;
    drain_check("bp drain");

    // Reset in the middle of a drain.
    load_batch(0);
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("mid reset flags", 32'({busy_a, out_valid_a, busy_d, out_valid_d}), 0);
    check("mid reset count", 32'({count_a, count_d}), 0);
    check("mid reset fields", 32'({col_a, idx_a, tot_a, col_d, idx_d, tot_d}), 0);
    q_a.delete();
    q_d.delete();

    load_batch(3);
    drain_check("color");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
